// File: rtl/cpu_io_port_if.sv
// rtl/cpu_io_port_if.sv - CPU strobe/address and host stream signals of cpu_io_port
//
// Signals:
//   addr      CPU address (16)
//   DI, DO    CPU write / read strobes
//   rx_*      host drain stream of words the CPU has written
//   tx_*      host fill stream of words the CPU will read
// master: the CPU/host side.
// slave: the port itself.
// The shared data bus is a plain inout on the port module, not part of this interface.

interface cpu_io_port_if;
    logic [15:0] addr;
    logic        DI;
    logic        DO;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addr, DI, DO, rx_ready, tx_data, tx_valid,
        input  rx_data, rx_valid, tx_ready
    );

    modport slave (
        input  addr, DI, DO, rx_ready, tx_data, tx_valid,
        output rx_data, rx_valid, tx_ready
    );
endinterface

// File: rtl/cpu_io_port.sv
// rtl/cpu_io_port.sv - CPU I/O strobe responder with RX/TX word FIFOs toward a host
//
// Ports:
//   clk        system clock, rising edge
//   reset_bar  asynchronous active-low reset
//   bus        16-bit shared CPU data bus, driven only during a selected DO
//   io         cpu_io_port_if.slave: addr, DI, DO, rx_data/rx_valid/rx_ready,
//              tx_data/tx_valid/tx_ready
// PORT_ADDR is the data register, PORT_ADDR+1 is the status register:
//   {12'b0, underflow, overflow, rx_not_full, tx_not_empty}

module cpu_io_port_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_bar,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] head_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    always_comb begin
        // A pop frees a slot in the same cycle, so a push into a full FIFO is
        // admitted when it coincides with a pop.
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            wr_d = wr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
            end
        end
    end
endmodule

module cpu_io_port #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] PORT_ADDR = 16'h0000
) (
    input  logic            clk,
    input  logic            reset_bar,
    inout  wire [15:0]      bus,
    cpu_io_port_if.slave    io
);
    localparam logic [15:0] STAT_ADDR = PORT_ADDR + 16'd1;

    logic        sel_data;
    logic        sel_stat;
    logic        rd_data;
    logic        rd_stat;
    logic        wr_data;
    logic        wr_stat;

    logic [15:0] rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_pop;
    logic [15:0] tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_push;
    logic        tx_pop;

    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic [15:0] rx_last_q, rx_last_d;

    logic        bus_oe;
    logic [15:0] bus_rd;

    assign sel_data = (io.addr == PORT_ADDR);
    assign sel_stat = (io.addr == STAT_ADDR);

    // DO has priority: a cycle with both strobes is treated as a pure read.
    assign rd_data = io.DO && sel_data;
    assign rd_stat = io.DO && sel_stat;
    assign wr_data = io.DI && !io.DO && sel_data;
    assign wr_stat = io.DI && !io.DO && sel_stat;

    assign rx_pop  = !rx_empty && io.rx_ready;
    assign tx_push = io.tx_valid && !tx_full;
    assign tx_pop  = rd_data && !tx_empty;

    cpu_io_port_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_bar (reset_bar),
        .push_i    (wr_data),
        .pop_i     (rx_pop),
        .wdata_i   (bus),
        .head_o    (rx_head),
        .full_o    (rx_full),
        .empty_o   (rx_empty)
    );

    cpu_io_port_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_bar (reset_bar),
        .push_i    (tx_push),
        .pop_i     (tx_pop),
        .wdata_i   (io.tx_data),
        .head_o    (tx_head),
        .full_o    (tx_full),
        .empty_o   (tx_empty)
    );

    always_comb begin
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        rx_last_d = rx_last_q;
        // Clear first so a set in the same cycle overrides it.
        if (wr_stat && bus[2]) begin
            ovf_d = 1'b0;
        end
        if (wr_stat && bus[3]) begin
            unf_d = 1'b0;
        end
        if (wr_data && rx_full && !rx_pop) begin
            ovf_d = 1'b1;
        end
        if (rd_data && tx_empty) begin
            unf_d = 1'b1;
        end
        // Remember each popped word so rx_data keeps showing it once empty.
        if (rx_pop) begin
            rx_last_d = rx_head;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rx_last_q <= 16'h0000;
        end else begin
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rx_last_q <= rx_last_d;
        end
    end

    always_comb begin
        bus_oe = 1'b0;
        bus_rd = 16'h0000;
        if (rd_data) begin
            bus_oe = 1'b1;
            bus_rd = tx_empty ? 16'h0000 : tx_head;
        end else if (rd_stat) begin
            bus_oe = 1'b1;
            bus_rd = {12'b0, unf_q, ovf_q, !rx_full, !tx_empty};
        end
    end

    assign bus = bus_oe ? bus_rd : 16'hzzzz;

    assign io.rx_data  = rx_empty ? rx_last_q : rx_head;
    assign io.rx_valid = !rx_empty;
    assign io.tx_ready = !tx_full;
endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Peripheral-side responder for the CPU's I/O strobes on the shared 16-bit bus.
- The CPU writes a word with DI and reads a word with DO. This block buffers CPU writes into an RX FIFO that a host drains, and serves CPU reads from a TX FIFO that a host fills.
- It sits beside the CPU on clk/reset_bar, decodes addr, and drives bus only during its own DO reads.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- PORT_ADDR, 16'h0000, base address; bit 0 must be 0. PORT_ADDR selects data, PORT_ADDR+1 selects status.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_bar  in  1  asynchronous active-low reset.
- addr  in  16  CPU address.
- bus  inout  16  CPU data bus. Driven by this block only when a read is selected, else high-Z.
- DI  in  1  CPU write strobe: the CPU drives bus into the device.
- DO  in  1  CPU read strobe: the device drives bus to the CPU.
- rx_data  out  16  head of the RX FIFO (words the CPU has written).
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  host pops the RX head on a rising edge when rx_valid is high.
- tx_data  in  16  word offered by the host for the CPU to read.
- tx_valid  in  1  host push request.
- tx_ready  out  1  TX FIFO not full.

Behaviour:
- Reset (asynchronous, on reset_bar low):
  - pointers and counts = 0, sticky flags = 0;
  - rx_valid = 0, rx_data = 16'h0000, tx_ready = 1, bus = Z;
  - a reset in the middle of any transfer discards all FIFO contents.
- Decode:
  - sel_data = (addr == PORT_ADDR);
  - sel_stat = (addr == PORT_ADDR+1);
  - any other addr: the block ignores DI/DO and leaves bus at Z.
- Reads (combinational drive, zero latency):
  - DO && sel_data: bus = TX head, or 16'h0000 if TX is empty.
  - DO && sel_stat: bus = {12'b0, underflow, overflow, rx_not_full, tx_not_empty}.
  - In every other case bus = Z.
- Read side effects (at the rising edge):
  - DO && sel_data with TX non-empty: pop TX.
  - DO && sel_data with TX empty: set underflow; no pop.
  - A held DO pops once per clock.
- CPU writes (sampled at the rising edge):
  - DI && sel_data: push bus into RX. If RX is full and the host is not popping RX in the same cycle, drop the word and set overflow.
  - DI && sel_stat: bus[2]=1 clears overflow, bus[3]=1 clears underflow; other bits are ignored.
- DI and DO both high: DO wins and DI is ignored for that cycle.
- Host side:
  - RX pop when rx_valid && rx_ready.
  - TX push when tx_valid && tx_ready.
  - A push and a pop on the same FIFO in the same cycle both take effect and the count is unchanged. On a full RX FIFO this admits a CPU push; on a full TX FIFO the push is still refused (tx_ready=0).
- FIFO implementation:
  - pointers are log2(DEPTH) bits and wrap modulo DEPTH;
  - count is log2(DEPTH)+1 bits and saturates at 0 and DEPTH;
  - flags derive from count.
- Output timing:
  - rx_data, rx_valid and tx_ready are registered-state derived and change only after a clock edge or reset;
  - rx_data holds its last value while the FIFO is empty.
- Overflow and underflow stay set until cleared by a status write or by reset. A set and a clear in the same cycle: set wins.

Test Plan:
- Reset:
  - stimulus: pulse reset_bar low, then DO at PORT_ADDR+1;
  - required: bus = 16'h0002 (rx_not_full=1), rx_valid=0, tx_ready=1.
- CPU write stream:
  - stimulus: CPU writes 1..4 via DI at PORT_ADDR with rx_ready=0, then a 5th write of 5;
  - required: status = 16'h0004 (overflow set, RX full); host drains 1,2,3,4 in order; rx_valid then 0.
- TX read:
  - stimulus: host pushes 16'hA5A5, 16'h5A5A; CPU issues DO at PORT_ADDR on two cycles, then a third;
  - required: bus = A5A5, then 5A5A, then 0000 with underflow set (status bit3).
- Simultaneous RX push and pop while full:
  - stimulus: CPU write of 9 in the same cycle the host pops (rx_ready=1);
  - required: no overflow, count stays 4, 9 is last out.
- Sticky clear:
  - stimulus: DI at PORT_ADDR+1 with bus = 16'h000C;
  - required: status bits 2 and 3 = 0, FIFO contents unaffected.
- Wrap, decode and mid-stream reset:
  - stimulus: 10 words pushed/popped through each FIFO so pointers wrap; DO at an unselected addr; reset_bar low with data queued;
  - required: data order preserved across the wrap; bus = Z for the unselected addr; both FIFOs empty immediately after reset.
